bg_ref_sequencer: RTL

Digital control sequencer for a bank of on-chip reference macros (bandgap variants) in a Tiny Tapeout tile. It selects which of `NCH` reference channels is powered and routed to the analog buffer, holds a per-channel trim code, and enforces break-before-make switching plus a settle interval before flagging the output valid. An optional scan mode steps through all channels at a programmable dwell. Commands arrive on the dedicated inputs; status is reported on the dedicated outputs.

---
 rtl/bg_seq_pkg.sv | 27 ++
 rtl/bg_cmd_sync.sv | 37 +++
 rtl/bg_ref_sequencer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/bg_seq_pkg.sv
// Shared types and constants for the reference-macro sequencer.
// Holds the FSM state enum, command opcodes, status bit positions and dwell constants.
package bg_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GAP    = 2'd1,
    ST_SETTLE = 2'd2,
    ST_READY  = 2'd3
  } state_e;

  localparam logic [1:0] OP_SELECT = 2'b00;
  localparam logic [1:0] OP_TRIM   = 2'b01;
  localparam logic [1:0] OP_SCAN   = 2'b10;
  localparam logic [1:0] OP_STOP   = 2'b11;

  localparam int CMD_STROBE_BIT = 7;

  localparam int ST_BIT_READY = 4;
  localparam int ST_BIT_SCAN  = 5;
  localparam int ST_BIT_ERR   = 6;
  localparam int ST_BIT_BUSY  = 7;

  localparam int         DWELL_BASE    = 8;
  localparam logic [2:0] DWELL_EXP_MAX = 3'd7;

endpackage

// File: rtl/bg_cmd_sync.sv
// Two-flop synchroniser for the command byte plus rising-edge detect on the strobe.
// Opcode and argument are taken from the same synchronised word as the strobe.
module bg_cmd_sync
  import bg_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic       cmd_vld,
  output logic [1:0] op,
  output logic [3:0] arg
);

  logic [7:0] sync1_q;
  logic [7:0] sync2_q;
  logic       strobePrev_q;
  logic       unusedBit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      strobePrev_q <= 1'b0;
    end else begin
      sync1_q      <= ui_in;
      sync2_q      <= sync1_q;
      strobePrev_q <= sync2_q[CMD_STROBE_BIT];
    end
  end

  // A held strobe yields a single pulse; it must fall before the next command.
  assign cmd_vld   = sync2_q[CMD_STROBE_BIT] & ~strobePrev_q;
  assign op        = sync2_q[6:5];
  assign arg       = sync2_q[3:0];
  assign unusedBit = sync2_q[4];

endmodule

// File: rtl/bg_ref_sequencer.sv
// Channel sequencer for a bank of reference macros: break-before-make selection,
// per-channel trim, settle timing and optional round-robin scan with a programmable dwell.
module bg_ref_sequencer
  import bg_seq_pkg::*;
#(
  parameter int NCH    = 2,
  parameter int TRIM_W = 4,
  parameter int SETTLE = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic [7:0]              ui_in,
  input  logic [7:0]              uio_in,
  output logic [7:0]              uo_out,
  output logic [7:0]              uio_out,
  output logic [7:0]              uio_oe,
  output logic [NCH-1:0]          ch_en,
  output logic [NCH*TRIM_W-1:0]   trim
);

  localparam int                CNT_MAX     = (SETTLE > 32768) ? SETTLE : 32768;
  localparam int                CNT_W       = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE - 1);
  localparam logic [TRIM_W-1:0] TRIM_RESET  = TRIM_W'(1 << (TRIM_W - 1));
  localparam logic [3:0]        CH_LAST     = 4'(NCH - 1);

  function automatic logic [CNT_W-1:0] dwellLoad(input logic [2:0] e);
    logic [31:0] span;
    span = 32'd1 << (32'(e) + 32'(DWELL_BASE));
    return CNT_W'(span - 32'd1);
  endfunction

  logic       cmdVld;
  logic [1:0] cmdOp;
  logic [3:0] cmdArg;
  logic       cmdFire;
  logic       unusedIn;

  state_e            state_q, state_d;
  logic [3:0]        chSel_q, chSel_d;
  logic              scan_q, scan_d;
  logic              err_q, err_d;
  logic [2:0]        scanExp_q, scanExp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TRIM_W-1:0] trimFile_q [NCH];
  logic [TRIM_W-1:0] trimFile_d [NCH];
  logic [NCH-1:0]    chEn_q, chEn_d;
  logic [7:0]        status_q, status_d;

  bg_cmd_sync uSync (
    .clk     (clk),
    .rst_n   (rst_n),
    .ui_in   (ui_in),
    .cmd_vld (cmdVld),
    .op      (cmdOp),
    .arg     (cmdArg)
  );

  assign unusedIn = ^uio_in;

  always_comb begin
    state_d   = state_q;
    chSel_d   = chSel_q;
    scan_d    = scan_q;
    err_d     = err_q;
    scanExp_d = scanExp_q;
    cnt_d     = cnt_q;
    trimFile_d = trimFile_q;
    cmdFire   = cmdVld & ena;

    // One shared down-counter times both the settle interval and the scan dwell.
    case (state_q)
      ST_GAP: begin
        state_d = ST_SETTLE;
        cnt_d   = SETTLE_LOAD;
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_READY;
          cnt_d   = dwellLoad(scanExp_q);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_READY: begin
        if (scan_q) begin
          if (cnt_q == '0) begin
            chSel_d = (chSel_q == CH_LAST) ? 4'd0 : chSel_q + 4'd1;
            state_d = ST_GAP;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: begin
      end
    endcase

    // Commands override any counter expiry in the same cycle.
    if (cmdFire) begin
      case (cmdOp)
        OP_SELECT: begin
          if (int'(cmdArg) < NCH) begin
            chSel_d = cmdArg;
            scan_d  = 1'b0;
            state_d = ST_GAP;
          end else begin
            err_d = 1'b1;
          end
        end
        OP_TRIM: begin
          for (int c = 0; c < NCH; c++) begin
            if (chSel_q == 4'(c)) trimFile_d[c] = cmdArg[TRIM_W-1:0];
          end
          chSel_d = chSel_q;
          if (state_q == ST_SETTLE || state_q == ST_READY) begin
            state_d = ST_SETTLE;
            cnt_d   = SETTLE_LOAD;
          end
        end
        OP_SCAN: begin
          scan_d    = 1'b1;
          scanExp_d = (cmdArg > {1'b0, DWELL_EXP_MAX}) ? DWELL_EXP_MAX : cmdArg[2:0];
          chSel_d   = chSel_q;
          state_d   = ST_GAP;
        end
        OP_STOP: begin
          scan_d  = 1'b0;
          err_d   = 1'b0;
          chSel_d = chSel_q;
          state_d = ST_IDLE;
        end
        default: begin
        end
      endcase
    end

    if (!ena) begin
      state_d = ST_IDLE;
      scan_d  = 1'b0;
      chSel_d = chSel_q;
    end

    chEn_d = '0;
    if (state_d == ST_SETTLE || state_d == ST_READY) begin
      for (int c = 0; c < NCH; c++) chEn_d[c] = (chSel_d == 4'(c));
    end

    status_d               = '0;
    status_d[3:0]          = chSel_d;
    status_d[ST_BIT_READY] = (state_d == ST_READY);
    status_d[ST_BIT_SCAN]  = scan_d;
    status_d[ST_BIT_ERR]   = err_d;
    status_d[ST_BIT_BUSY]  = (state_d == ST_GAP) || (state_d == ST_SETTLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      chSel_q   <= '0;
      scan_q    <= 1'b0;
      err_q     <= 1'b0;
      scanExp_q <= '0;
      cnt_q     <= '0;
      chEn_q    <= '0;
      status_q  <= '0;
      for (int c = 0; c < NCH; c++) trimFile_q[c] <= TRIM_RESET;
    end else begin
      state_q    <= state_d;
      chSel_q    <= chSel_d;
      scan_q     <= scan_d;
      err_q      <= err_d;
      scanExp_q  <= scanExp_d;
      cnt_q      <= cnt_d;
      chEn_q     <= chEn_d;
      status_q   <= status_d;
      trimFile_q <= trimFile_d;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : gTrim
    assign trim[c*TRIM_W +: TRIM_W] = trimFile_q[c];
  end

  assign ch_en   = chEn_q;
  assign uo_out  = status_q;
  assign uio_out = '0;
  assign uio_oe  = '0;

endmodule
